// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and helpers for the bomb-game MMIO responder.
//   - Register offsets within the 16-word I/O window.
//   - Bit positions inside the CTRL and STATUS registers.
//   - in_window(): decodes whether a bus address falls in the I/O window.
package mmio_pkg;

  localparam logic [3:0] OFF_TIMER    = 4'h0;
  localparam logic [3:0] OFF_CTRL     = 4'h1;
  localparam logic [3:0] OFF_STATUS   = 4'h2;
  localparam logic [3:0] OFF_STRIKE   = 4'h3;
  localparam logic [3:0] OFF_SWITCHES = 4'h4;
  localparam logic [3:0] OFF_LEDS     = 4'h5;
  localparam logic [3:0] OFF_EVENT    = 4'h6;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_REARM_BIT = 2;

  localparam int STAT_RUNNING_BIT  = 0;
  localparam int STAT_EXPIRED_BIT  = 1;
  localparam int STAT_EXPLODED_BIT = 2;
  localparam int STAT_STRIKES_LSB  = 4;

  // Window match ignores the word offset in bits [3:0].
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    return (addr[15:4] == base[15:4]);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle tick.
//   clock  : system clock
//   reset  : synchronous active-high reset
//   enable : count while high; the counter is held at 0 while low
//   clear  : force the counter back to 0 (restart the current period)
//   tick   : high for one cycle when the counter sits at TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  // Period counter: 0..TICK_DIV-1, parked at 0 when disabled or cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || !enable) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // A clear in the terminal cycle restarts the period instead of ticking.
  assign tick = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/mmio_bomb_responder.sv
// mmio_bomb_responder: RAM-side MMIO responder holding the bomb game state.
//   clock, reset            : system clock, synchronous active-high reset
//   read_addr, q, hit       : read port; q/hit registered (1-cycle latency like block RAM)
//   write_addr, data, we    : write port; only in-window addresses take effect
//   switches_in             : asynchronous switch pins (synchronized internally)
//   leds_out                : LED register
//   exploded                : explosion flag (level)
module mmio_bomb_responder
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          TICK_DIV    = 50000000,
  parameter int          MAX_STRIKES = 3,
  parameter int          SW_WIDTH    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         read_addr,
  input  logic [15:0]         write_addr,
  input  logic [15:0]         data,
  input  logic                we,
  output logic [15:0]         q,
  output logic                hit,
  input  logic [SW_WIDTH-1:0] switches_in,
  output logic [SW_WIDTH-1:0] leds_out,
  output logic                exploded
);

  localparam logic [1:0] STRIKE_MAX = 2'(MAX_STRIKES);

  logic [15:0]         r_timer;
  logic                r_running;
  logic                r_expired;
  logic                r_exploded;
  logic [1:0]          r_strikes;
  logic [SW_WIDTH-1:0] r_leds;
  logic [SW_WIDTH-1:0] r_sw_s1;
  logic [SW_WIDTH-1:0] r_sw_s2;
  logic [SW_WIDTH-1:0] r_sw_s3;
  logic [SW_WIDTH-1:0] r_event;
  logic [15:0]         r_q;
  logic                r_hit;

  logic                w_rd_hit;
  logic [3:0]          w_rd_off;
  logic                w_wr_hit;
  logic [3:0]          w_wr_off;
  logic                w_timer_wr;
  logic                w_ctrl_wr;
  logic                w_strike_wr;
  logic                w_leds_wr;
  logic                w_event_clr;
  logic                w_tick;
  logic [SW_WIDTH-1:0] w_sw_edge;
  logic [SW_WIDTH-1:0] w_event_nxt;
  logic [15:0]         w_timer_nxt;
  logic                w_running_nxt;
  logic                w_expired_nxt;
  logic                w_exploded_nxt;
  logic [1:0]          w_strikes_nxt;
  logic [15:0]         w_status;
  logic [15:0]         w_sw_ext;
  logic [15:0]         w_leds_ext;
  logic [15:0]         w_event_ext;
  logic [15:0]         w_rd_data;

  assign w_rd_hit    = in_window(read_addr, BASE_ADDR);
  assign w_rd_off    = read_addr[3:0];
  assign w_wr_hit    = we && in_window(write_addr, BASE_ADDR);
  assign w_wr_off    = write_addr[3:0];
  assign w_timer_wr  = w_wr_hit && (w_wr_off == OFF_TIMER);
  assign w_ctrl_wr   = w_wr_hit && (w_wr_off == OFF_CTRL);
  assign w_strike_wr = w_wr_hit && (w_wr_off == OFF_STRIKE);
  assign w_leds_wr   = w_wr_hit && (w_wr_off == OFF_LEDS);
  assign w_event_clr = w_rd_hit && (w_rd_off == OFF_EVENT);
  assign w_sw_edge   = r_sw_s2 ^ r_sw_s3;

  // Any TIMER write restarts the current one-second period.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(r_running),
    .clear (w_timer_wr),
    .tick  (w_tick)
  );

  // Game-state next values; updates are layered timer -> CTRL -> STRIKE.
  always_comb begin
    w_timer_nxt    = r_timer;
    w_running_nxt  = r_running;
    w_expired_nxt  = r_expired;
    w_exploded_nxt = r_exploded;
    w_strikes_nxt  = r_strikes;

    // A software load overrides the countdown; loading 0 stops without expiring.
    if (w_timer_wr) begin
      w_timer_nxt = data;
      if (data == 16'h0000) begin
        w_running_nxt = 1'b0;
      end else begin
        w_running_nxt = r_running;
      end
    end else if (w_tick) begin
      if (r_timer > 16'd1) begin
        w_timer_nxt = r_timer - 16'd1;
      end else if (r_timer == 16'd1) begin
        w_timer_nxt    = 16'h0000;
        w_running_nxt  = 1'b0;
        w_expired_nxt  = 1'b1;
        w_exploded_nxt = 1'b1;
      end else begin
        w_timer_nxt = 16'h0000;
      end
    end else begin
      w_timer_nxt = r_timer;
    end

    // Rearm is applied before the run bit so one write can rearm and start.
    if (w_ctrl_wr) begin
      if (data[CTRL_REARM_BIT]) begin
        w_strikes_nxt  = 2'd0;
        w_expired_nxt  = 1'b0;
        w_exploded_nxt = 1'b0;
        w_running_nxt  = 1'b0;
      end else begin
        w_strikes_nxt = w_strikes_nxt;
      end
      if (data[CTRL_RUN_BIT]) begin
        if ((w_timer_nxt != 16'h0000) && !w_exploded_nxt) begin
          w_running_nxt = 1'b1;
        end else begin
          w_running_nxt = w_running_nxt;
        end
      end else begin
        w_running_nxt = 1'b0;
      end
    end else begin
      w_running_nxt = w_running_nxt;
    end

    // Gated on the registered flag so a same-cycle expiry does not block the strike.
    if (w_strike_wr && !r_exploded) begin
      if (r_strikes < STRIKE_MAX) begin
        w_strikes_nxt = r_strikes + 2'd1;
      end else begin
        w_strikes_nxt = r_strikes;
      end
      if (w_strikes_nxt == STRIKE_MAX) begin
        w_exploded_nxt = 1'b1;
        w_running_nxt  = 1'b0;
      end else begin
        w_exploded_nxt = w_exploded_nxt;
      end
    end else begin
      w_strikes_nxt = w_strikes_nxt;
    end
  end

  // Edge flags are sticky; a new edge in the clearing cycle survives the clear.
  always_comb begin
    w_event_nxt = r_event;
    if (w_event_clr) begin
      w_event_nxt = w_sw_edge;
    end else begin
      w_event_nxt = r_event | w_sw_edge;
    end
  end

  // Read mux sees only pre-write register values (read-before-write).
  always_comb begin
    w_status                                 = 16'h0000;
    w_status[STAT_RUNNING_BIT]               = r_running;
    w_status[STAT_EXPIRED_BIT]               = r_expired;
    w_status[STAT_EXPLODED_BIT]              = r_exploded;
    w_status[STAT_STRIKES_LSB +: 2]          = r_strikes;
    w_sw_ext                                 = 16'h0000;
    w_sw_ext[SW_WIDTH-1:0]                   = r_sw_s2;
    w_leds_ext                               = 16'h0000;
    w_leds_ext[SW_WIDTH-1:0]                 = r_leds;
    w_event_ext                              = 16'h0000;
    w_event_ext[SW_WIDTH-1:0]                = r_event;
    w_rd_data                                = 16'h0000;
    case (w_rd_off)
      OFF_TIMER:    w_rd_data = r_timer;
      OFF_CTRL:     w_rd_data = {15'h0000, r_running};
      OFF_STATUS:   w_rd_data = w_status;
      OFF_SWITCHES: w_rd_data = w_sw_ext;
      OFF_LEDS:     w_rd_data = w_leds_ext;
      OFF_EVENT:    w_rd_data = w_event_ext;
      default:      w_rd_data = 16'h0000;
    endcase
  end

  // State registers, switch synchronizer and registered read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer    <= 16'h0000;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_exploded <= 1'b0;
      r_strikes  <= 2'd0;
      r_leds     <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_sw_s3    <= '0;
      r_event    <= '0;
      r_q        <= 16'h0000;
      r_hit      <= 1'b0;
    end else begin
      r_timer    <= w_timer_nxt;
      r_running  <= w_running_nxt;
      r_expired  <= w_expired_nxt;
      r_exploded <= w_exploded_nxt;
      r_strikes  <= w_strikes_nxt;
      if (w_leds_wr) begin
        r_leds <= data[SW_WIDTH-1:0];
      end else begin
        r_leds <= r_leds;
      end
      r_sw_s1 <= switches_in;
      r_sw_s2 <= r_sw_s1;
      r_sw_s3 <= r_sw_s2;
      r_event <= w_event_nxt;
      r_hit   <= w_rd_hit;
      r_q     <= w_rd_hit ? w_rd_data : 16'h0000;
    end
  end

  assign q        = r_q;
  assign hit      = r_hit;
  assign leds_out = r_leds;
  assign exploded = r_exploded;

endmodule

// File: tb/tb_mmio_bomb_responder.sv
// Bench for mmio_bomb_responder (TICK_DIV=4, MAX_STRIKES=3).
// Reads push their expected {hit,q} into a queue; a monitor pops and compares
// on the negedge after each issued read.
module tb_mmio_bomb_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] read_addr;
  logic [15:0] write_addr;
  logic [15:0] data;
  logic        we;
  logic [15:0] q;
  logic        hit;
  logic [7:0]  switches_in;
  logic [7:0]  leds_out;
  logic        exploded;

  typedef struct {
    logic        hit;
    logic [15:0] q;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rd_chk = 1'b0;

  always #5 clock = ~clock;

  mmio_bomb_responder #(
    .BASE_ADDR  (16'hFF00),
    .TICK_DIV   (4),
    .MAX_STRIKES(3),
    .SW_WIDTH   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .data       (data),
    .we         (we),
    .q          (q),
    .hit        (hit),
    .switches_in(switches_in),
    .leds_out   (leds_out),
    .exploded   (exploded)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, optionally queue an expected read result.
  task automatic step(input logic [15:0] ra, input bit chk, input logic [15:0] eq,
                      input logic eh, input string nm,
                      input logic [15:0] wa, input logic w, input logic [15:0] wd);
    exp_t e;
    read_addr  = ra;
    rd_chk     = chk;
    write_addr = wa;
    we         = w;
    data       = wd;
    if (chk) begin
      e.hit  = eh;
      e.q    = eq;
      e.name = nm;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(16'h0000, 1'b0, 16'h0000, 1'b0, "", 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    step(a, 1'b1, exp, 1'b1, nm, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(16'h0000, 1'b0, 16'h0000, 1'b0, "", a, 1'b1, d);
  endtask

  // Monitor: compares the registered read result against the queue head.
  initial begin
    bit   p;
    exp_t e;
    forever begin
      @(posedge clock);
      p = rd_chk;
      @(negedge clock);
      if (p) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got no expectation want one");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hit"}, {15'h0000, hit}, {15'h0000, e.hit});
          check(e.name, q, e.q);
        end
      end else if (hit !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL stray_hit: got %b want 0", hit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    read_addr   = 16'h0000;
    write_addr  = 16'h0000;
    data        = 16'h0000;
    we          = 1'b0;
    switches_in = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_hit", {15'h0000, hit}, 16'h0000);
    check("rst_q", q, 16'h0000);
    check("rst_leds", {8'h00, leds_out}, 16'h0000);
    check("rst_exploded", {15'h0000, exploded}, 16'h0000);

    // Window decode.
    rd(16'hFF02, 16'h0000, "status_rst");
    step(16'h0010, 1'b1, 16'h0000, 1'b0, "out_of_window", 16'h0000, 1'b0, 16'h0000);

    // Countdown to expiry: one tick every 4 cycles once running.
    wr(16'hFF00, 16'd2);
    wr(16'hFF01, 16'h0001);
    repeat (4) idle();
    rd(16'hFF00, 16'd1, "timer_1");
    repeat (3) idle();
    rd(16'hFF00, 16'd0, "timer_0");
    rd(16'hFF02, 16'h0006, "status_expired");
    check("exploded_expiry", {15'h0000, exploded}, 16'h0001);

    // Strikes: rearm, then three strikes to explode, a fourth saturates.
    wr(16'hFF01, 16'h0004);
    check("rearm_clears", {15'h0000, exploded}, 16'h0000);
    wr(16'hFF03, 16'h1234);
    rd(16'hFF02, 16'h0010, "strike1");
    wr(16'hFF03, 16'h0000);
    rd(16'hFF02, 16'h0020, "strike2");
    wr(16'hFF03, 16'hFFFF);
    rd(16'hFF02, 16'h0034, "strike3");
    check("exploded_strikes", {15'h0000, exploded}, 16'h0001);
    wr(16'hFF03, 16'h0001);
    rd(16'hFF02, 16'h0034, "strike_sat");

    // Rearm+run in one write, then run ignored with TIMER=0.
    wr(16'hFF00, 16'd5);
    wr(16'hFF01, 16'h0005);
    rd(16'hFF02, 16'h0001, "rearm_run_status");
    rd(16'hFF01, 16'h0001, "ctrl_running");
    check("exploded_cleared", {15'h0000, exploded}, 16'h0000);
    wr(16'hFF00, 16'd0);
    rd(16'hFF02, 16'h0000, "timer0_stops");
    wr(16'hFF01, 16'h0001);
    rd(16'hFF02, 16'h0000, "run_ignored_t0");
    rd(16'hFF00, 16'h0000, "timer_still_0");

    // Switch synchronizer and sticky edge flags.
    switches_in = 8'hA5;
    idle();
    rd(16'hFF04, 16'h0000, "switches_lag");
    rd(16'hFF04, 16'h00A5, "switches");
    rd(16'hFF06, 16'h00A5, "event_set");
    rd(16'hFF06, 16'h0000, "event_cleared");
    switches_in = 8'h25;
    idle();
    switches_in = 8'h24;
    idle();
    idle();
    rd(16'hFF06, 16'h0080, "event_b7");
    rd(16'hFF06, 16'h0001, "event_kept");
    rd(16'hFF06, 16'h0000, "event_clr2");
    rd(16'hFF04, 16'h0024, "switches2");

    // LEDS read-before-write.
    step(16'hFF05, 1'b1, 16'h0000, 1'b1, "leds_rbw", 16'hFF05, 1'b1, 16'h003C);
    check("leds_out", {8'h00, leds_out}, 16'h003C);
    rd(16'hFF05, 16'h003C, "leds_read");
    rd(16'hFF07, 16'h0000, "unmapped");

    repeat (3) idle();
    check("sb_drained", 16'(sb.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_bomb_responder.md
Name: mmio_bomb_responder

Overview:
- Memory-mapped peripheral responder on the datapath's RAM-side bus: it answers loads and stores that fall in a 16-word I/O window instead of block RAM.
- Holds the game state: bomb countdown timer, strike counter, explode flag, synchronized module switches and LED outputs.
- Mirrors block RAM timing (registered read data, 1-cycle latency), so the datapath muxes q against block RAM using the registered hit.

Parameters:
- BASE_ADDR, 16'hFF00, base of the 16-word I/O window; low 4 bits must be 0.
- TICK_DIV, 50000000, clock cycles per timer decrement (1 s at 50 MHz); must be >= 2.
- MAX_STRIKES, 3, strike count that triggers explosion; range 1..3.
- SW_WIDTH, 8, number of switch inputs and LED outputs.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; applied on a rising clock edge.
- read_addr  in  16  datapath read address.
- write_addr  in  16  datapath write address.
- data  in  16  write data.
- we  in  1  write enable; a write occurs only when write_addr is in the window.
- q  out  16  registered read data for the in-window read_addr of the previous cycle; 0 otherwise.
- hit  out  1  registered: read_addr was in the window in the previous cycle.
- switches_in  in  SW_WIDTH  asynchronous switch inputs.
- leds_out  out  SW_WIDTH  LED register.
- exploded  out  1  explosion flag, level.

Behaviour:
- Window decode: addr[15:4] == BASE_ADDR[15:4]. Offset is addr[3:0].
- Register map:
  - 0x0 TIMER (RW): 16-bit seconds remaining.
  - 0x1 CTRL (W): bit0 = run, bit2 = rearm (pulse); reads return {15'b0, running}.
  - 0x2 STATUS (RO): bit0 running, bit1 expired, bit2 exploded, bits5:4 strikes.
  - 0x3 STRIKE (W): any data increments strikes.
  - 0x4 SWITCHES (RO): synchronized switches, zero-extended.
  - 0x5 LEDS (RW).
  - 0x6 EVENT (RO, clear-on-read): sticky per-bit flag for any edge on a synchronized switch.
  - Other offsets read 0; writes to them are ignored.
- Reset values: q=0, hit=0, leds_out=0, exploded=0, TIMER=0, running=0, expired=0, strikes=0, EVENT=0, prescaler=0, sync flops=0.
- Read: 1-cycle latency. A same-cycle write to the same register returns the old value (read-before-write).
- Switches: 2-flop synchronizer, plus a third flop for edge detect. The SWITCHES value lags the pins by 2 cycles.
- EVENT read-clear: if a new edge arrives in the same cycle as the clearing read, that bit stays set.
- Prescaler:
  - Counts 0..TICK_DIV-1 while running and emits a 1-cycle tick at TICK_DIV-1.
  - Held at 0 when not running.
  - Reset to 0 on any TIMER write.
- Timer:
  - On a tick with TIMER > 1: TIMER decrements.
  - On a tick with TIMER == 1: TIMER becomes 0, running clears, expired and exploded set.
  - No wrap below 0.
- CTRL run write:
  - run=1 with TIMER == 0 is ignored (running stays 0).
  - run=1 while exploded is ignored.
  - run=0 pauses; the prescaler resets.
- TIMER write while running: loads the new value and continues. Writing 0 while running clears running without setting expired.
- STRIKE write:
  - strikes++ saturating at MAX_STRIKES.
  - Reaching MAX_STRIKES sets exploded and clears running.
  - Ignored while exploded.
- Simultaneous expiry tick and STRIKE write: both apply; exploded set once.
- Rearm: clears strikes, expired, exploded and running. TIMER is unchanged. If rearm and run are set in the same write, rearm applies first, then the run rule.
- Exploded freezes TIMER. Only reset or rearm clears it.

Decomposition:
- Shared package `mmio_pkg`:
  - register offset constants (OFF_TIMER .. OFF_EVENT);
  - STATUS and CTRL bit-index constants;
  - window-decode helper function.
- One sub-module, `tick_prescaler` (parameter TICK_DIV; ports clock, reset, enable, clear, tick), instantiated once.

Test Plan (bench uses TICK_DIV=4, MAX_STRIKES=3):
- Reset, then read 0xFF02 -> next cycle hit=1, q=0x0000; read 0x0010 -> hit=0, q=0.
- Write TIMER=2, CTRL=1 -> TIMER reads 1 after 4 cycles, 0 after 8. STATUS then reads 0x0006, exploded=1.
- Three STRIKE writes spaced 1 cycle apart -> STATUS 0x0010, 0x0020, then 0x0034 with exploded=1. A 4th write leaves strikes=3.
- Exploded, then write CTRL=0x5 with TIMER=5 -> STATUS=0x0001, running, strikes=0. CTRL=1 with TIMER=0 -> running stays 0.
- switches_in 0x00 -> 0xA5 -> SWITCHES reads 0xA5 from cycle+2 and EVENT reads 0xA5. The next EVENT read returns 0; an edge coinciding with the clearing read stays set.
- Write LEDS=0x3C and read 0xFF05 in the same cycle -> q=old 0x00. The next read gives 0x3C, and leds_out=0x3C one cycle after the write.
